pht_update_ctrl: RTL and testbench
==================================

Name: pht_update_ctrl

Overview:
- Sequences retire-time updates into the 2-bit saturating-counter pattern history table.
- Up to two conditional branches retire per cycle, but the PHT has a single update port. This block buffers retire outcomes in an in-order FIFO and drains exactly one update per cycle onto the PHT port.
- Provides a hold input and a drain handshake, so the PHT can be quiesced before checkpoint or halt.

Parameters:
- QUEUE_DEPTH, 8, FIFO entries; power of two, >= 4.
- RT_WIDTH, 2, retire slots per cycle; fixed at 2 in this revision.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rt_valid  in  [RT_WIDTH-1:0]  slot i retires a conditional branch this cycle.
- rt_pc  in  [RT_WIDTH-1:0][63:0]  PC of the retiring branch in slot i.
- rt_taken  in  [RT_WIDTH-1:0]  resolved direction for slot i (1 = taken).
- rt_ready  out  1  FIFO accepts both slots this cycle.
- hold  in  1  blocks dequeue this cycle (PHT port in use or frozen).
- drain_req  in  1  level request to empty the FIFO and block new intake.
- drained  out  1  FIFO empty and intake blocked; drain complete.
- pht_enable  out  1  drives the PHT enable input.
- pht_rt_branch  out  1  drives the PHT update-valid input.
- pht_rt_pc  out  64  drives the PHT update PC.
- pht_rt_taken  out  1  drives the PHT update direction.
- occupancy  out  $clog2(QUEUE_DEPTH+1)  current FIFO count.
- ovf_err  out  1  sticky flag: an enqueue arrived while rt_ready was 0.

Behaviour:
- Storage: circular FIFO of {pc[63:0], taken}, with head/tail pointers of width $clog2(QUEUE_DEPTH) that wrap modulo QUEUE_DEPTH, plus a registered count.
- Enqueue order:
  - When rt_ready=1, valid slots enqueue in slot order, slot0 before slot1.
  - If only slot1 is valid, it takes the tail position alone.
  - The number enqueued equals popcount(rt_valid).
- rt_ready:
  - Equals (state==RUN) && (QUEUE_DEPTH - count >= 2).
  - Computed from registered state only; it does not credit the same-cycle dequeue.
- Overflow: any rt_valid bit high while rt_ready=0 drops that entry (no enqueue) and sets ovf_err. ovf_err clears only on reset.
- Dequeue:
  - pht_rt_branch = (count != 0) && !hold.
  - pht_rt_pc and pht_rt_taken come combinationally from the head entry.
  - The head advances on the same posedge that pht_rt_branch is 1.
  - When count==0, pht_rt_pc and pht_rt_taken are 0.
- pht_enable = !hold.
- Latency:
  - An entry enqueued at posedge N appears on the PHT port in cycle N+1 at the earliest, provided the FIFO was empty and hold=0.
  - The PHT then updates its counter at posedge N+2.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_n - deq. Dequeue order is strictly FIFO.
- FSM:
  - RUN: normal operation. On drain_req=1 -> DRAIN.
  - DRAIN:
    - rt_ready is forced to 0; dequeue continues and still obeys hold.
    - When count==0 -> DONE. If count==0 on entry, DRAIN lasts one cycle.
    - If drain_req drops before empty -> RUN; remaining entries stay queued.
  - DONE: drained=1. While drain_req=1, stay in DONE. When drain_req=0 -> RUN; drained deasserts the same cycle.
- Reset values: state=RUN, head=tail=count=0, ovf_err=0, drained=0. With the FIFO empty, rt_ready=1.
- Reset mid-operation: all queued updates are discarded, and no PHT update is issued in the reset cycle.
- PC bits are passed unmodified. The PHT does its own index extraction from pc[log2(PHT_ROW)+1:2].

Decomposition:
- Shared package sys_defs: typedef PHT_UPD_ENTRY {logic [63:0] pc; logic taken;}; enum PHT_CTRL_STATE {RUN, DRAIN, DONE}; existing `PHT_ROW.
- One sub-module: pht_upd_fifo (multi-write, single-read circular buffer, parameterised on depth and write width). FSM and port muxing stay in pht_update_ctrl.

Test Plan:
- Reset, then rt_valid=2'b11, pc0=0x100 taken=1, pc1=0x104 taken=0 -> cycle+1: pht_rt_pc=0x100, taken=1; cycle+2: pc=0x104, taken=0; cycle+3: pht_rt_branch=0, occupancy=0.
- Only slot1 valid with pc=0x200, followed one cycle later by slot0 pc=0x300 -> drain order is 0x200 then 0x300.
- Enqueue 2/cycle with hold=1 for 4 cycles at QUEUE_DEPTH=8 -> occupancy reaches 8 and rt_ready=0 at count 7 and 8. Further rt_valid=2'b01 sets ovf_err=1 and occupancy stays 8. Release hold -> 8 updates issue in enqueue order.
- 3 entries queued, drain_req=1, hold toggling 1/0 -> rt_ready=0 throughout; drained=1 exactly after the 3rd dequeue. Drop drain_req -> RUN and rt_ready=1 the next cycle.
- Pointer wrap: 20 single enqueues with continuous dequeue -> every PC emerges in order across the wraparound at 8 entries; occupancy never exceeds 2.
- Reset asserted with 5 entries queued -> next cycle occupancy=0, pht_rt_branch=0, ovf_err=0, state RUN.

Source files
------------

// File: rtl/pht_update_ctrl_pkg.sv
// Shared types for the PHT retire-update controller: FIFO entry layout and control FSM states.
package pht_update_ctrl_pkg;

    localparam int unsigned PhtRow = 512;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
    } pht_upd_entry_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone
    } pht_ctrl_state_e;

endpackage

// File: rtl/pht_update_ctrl_if.sv
// Retire-side intake, drain control and PHT update port of the PHT update controller.
interface pht_update_ctrl_if #(
    parameter int unsigned QueueDepth = 8,
    parameter int unsigned RtWidth    = 2
);
    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    logic [RtWidth-1:0]        rt_valid;
    logic [RtWidth-1:0][63:0]  rt_pc;
    logic [RtWidth-1:0]        rt_taken;
    logic                      rt_ready;
    logic                      hold;
    logic                      drain_req;
    logic                      drained;
    logic                      pht_enable;
    logic                      pht_rt_branch;
    logic [63:0]               pht_rt_pc;
    logic                      pht_rt_taken;
    logic [CntW-1:0]           occupancy;
    logic                      ovf_err;

    modport master (
        output rt_valid, rt_pc, rt_taken, hold, drain_req,
        input  rt_ready, drained, pht_enable, pht_rt_branch, pht_rt_pc, pht_rt_taken,
        input  occupancy, ovf_err
    );

    modport slave (
        input  rt_valid, rt_pc, rt_taken, hold, drain_req,
        output rt_ready, drained, pht_enable, pht_rt_branch, pht_rt_pc, pht_rt_taken,
        output occupancy, ovf_err
    );
endinterface

// File: rtl/pht_upd_fifo.sv
// Multi-write, single-read circular buffer; valid write slots are packed in slot order at tail.
module pht_upd_fifo
    import pht_update_ctrl_pkg::*;
#(
    parameter int unsigned Depth   = 8,
    parameter int unsigned WrWidth = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WrWidth-1:0]             wr_en,
    input  pht_upd_entry_t [WrWidth-1:0]   wr_data,
    input  logic                           rd_en,
    output pht_upd_entry_t                 rd_data,
    output logic [$clog2(Depth+1)-1:0]     count
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    pht_upd_entry_t   mem_q [Depth];
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;
    logic [PtrW-1:0]  wr_idx [WrWidth];
    logic [CntW-1:0]  enq_n;
    logic             deq;

    // Each valid slot lands after the valid slots before it, so gaps in wr_en are squeezed out.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < int'(WrWidth); i++) begin
            wr_idx[i] = tail_q + PtrW'(enq_n);
            enq_n     = enq_n + CntW'(wr_en[i]);
        end
    end

    assign deq = rd_en && (count_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PtrW'(deq);
            tail_q  <= tail_q + PtrW'(enq_n);
            count_q <= count_q + enq_n - CntW'(deq);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(WrWidth); i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= wr_data[i];
        end
    end

    assign rd_data = (count_q != '0) ? mem_q[head_q] : '0;
    assign count   = count_q;
endmodule

// File: rtl/pht_update_ctrl.sv
// Buffers up to two retire outcomes per cycle and drains one update per cycle onto the PHT port.
module pht_update_ctrl
    import pht_update_ctrl_pkg::*;
#(
    parameter int unsigned QueueDepth = 8,
    parameter int unsigned RtWidth    = 2
) (
    input logic               clock,
    input logic               reset,
    pht_update_ctrl_if.slave  bus
);
    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    pht_ctrl_state_e                state_q, state_d;
    logic [CntW-1:0]                count;
    logic                           rt_ready;
    logic [RtWidth-1:0]             wr_en;
    pht_upd_entry_t [RtWidth-1:0]   wr_data;
    pht_upd_entry_t                 head;
    logic                           deq;
    logic                           ovf_q;

    // Ready looks only at registered count; a same-cycle dequeue is not credited.
    assign rt_ready = (state_q == StRun) && (count <= CntW'(QueueDepth - 2));
    assign wr_en    = bus.rt_valid & {RtWidth{rt_ready}};
    assign deq      = (count != '0) && !bus.hold && !reset;

    always_comb begin
        for (int i = 0; i < int'(RtWidth); i++) begin
            wr_data[i] = '{pc: bus.rt_pc[i], taken: bus.rt_taken[i]};
        end
    end

    pht_upd_fifo #(
        .Depth   (QueueDepth),
        .WrWidth (RtWidth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (deq),
        .rd_data (head),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((|bus.rt_valid) && !rt_ready) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (bus.drain_req) state_d = StDrain;
            StDrain: begin
                if (!bus.drain_req)    state_d = StRun;
                else if (count == '0)  state_d = StDone;
            end
            StDone:  if (!bus.drain_req) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign bus.rt_ready      = rt_ready;
    assign bus.drained       = (state_q == StDone);
    assign bus.pht_enable    = !bus.hold;
    assign bus.pht_rt_branch = deq;
    assign bus.pht_rt_pc     = head.pc;
    assign bus.pht_rt_taken  = head.taken;
    assign bus.occupancy     = count;
    assign bus.ovf_err       = ovf_q;
endmodule

// File: tb/tb_pht_update_ctrl.sv
// Scoreboard bench: stimulus queues expected PHT updates, a negedge monitor pops and compares.
module tb_pht_update_ctrl;
    import pht_update_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   deq_seen = 0;
    pht_upd_entry_t exp_q [$];

    always #5 clock = ~clock;

    pht_update_ctrl_if #(.QueueDepth(8), .RtWidth(2)) bus ();

    pht_update_ctrl #(.QueueDepth(8), .RtWidth(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one retire cycle; accepted entries are queued as expected PHT updates in slot order.
    task automatic enq(input logic [1:0] v, input logic [63:0] pc0, input logic t0,
                       input logic [63:0] pc1, input logic t1);
        bus.rt_valid = v;
        bus.rt_pc[0] = pc0;
        bus.rt_taken[0] = t0;
        bus.rt_pc[1] = pc1;
        bus.rt_taken[1] = t1;
        if (bus.rt_ready) begin
            if (v[0]) exp_q.push_back('{pc: pc0, taken: t0});
            if (v[1]) exp_q.push_back('{pc: pc1, taken: t1});
        end
        step();
        bus.rt_valid = 2'b00;
    endtask

    initial begin : monitor
        pht_upd_entry_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.pht_rt_branch === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_update: got pc %0h expected no update", bus.pht_rt_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pht_pc", bus.pht_rt_pc, e.pc);
                    check("pht_taken", 64'(bus.pht_rt_taken), 64'(e.taken));
                    deq_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        bit done;
        bus.rt_valid = '0;
        bus.rt_pc = '0;
        bus.rt_taken = '0;
        bus.hold = 1'b0;
        bus.drain_req = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        check("rst_occ", 64'(bus.occupancy), 0);
        check("rst_ready", 64'(bus.rt_ready), 1);
        check("rst_drained", 64'(bus.drained), 0);
        check("rst_ovf", 64'(bus.ovf_err), 0);
        check("rst_branch", 64'(bus.pht_rt_branch), 0);

        // Dual retire, first-update latency and order
        enq(2'b11, 64'h100, 1'b1, 64'h104, 1'b0);
        check("t1_branch0", 64'(bus.pht_rt_branch), 1);
        check("t1_pc0", bus.pht_rt_pc, 64'h100);
        check("t1_taken0", 64'(bus.pht_rt_taken), 1);
        check("t1_occ2", 64'(bus.occupancy), 2);
        step();
        check("t1_pc1", bus.pht_rt_pc, 64'h104);
        check("t1_taken1", 64'(bus.pht_rt_taken), 0);
        step();
        check("t1_branch_end", 64'(bus.pht_rt_branch), 0);
        check("t1_occ_end", 64'(bus.occupancy), 0);
        check("t1_pc_empty", bus.pht_rt_pc, 0);

        // Slot1-only then slot0-only
        enq(2'b10, 64'h0, 1'b0, 64'h200, 1'b1);
        enq(2'b01, 64'h300, 1'b0, 64'h0, 1'b0);
        step();
        check("t2_occ_end", 64'(bus.occupancy), 0);

        // Fill under hold, overflow, release
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++)
            enq(2'b11, 64'h1000 + 64'(2*i), i[0], 64'h1001 + 64'(2*i), ~i[0]);
        check("t3_occ_full", 64'(bus.occupancy), 8);
        check("t3_ready_full", 64'(bus.rt_ready), 0);
        check("t3_enable_hold", 64'(bus.pht_enable), 0);
        check("t3_branch_hold", 64'(bus.pht_rt_branch), 0);
        enq(2'b01, 64'h9999, 1'b1, 64'h0, 1'b0);
        check("t3_ovf", 64'(bus.ovf_err), 1);
        check("t3_occ_ovf", 64'(bus.occupancy), 8);
        bus.hold = 1'b0;
        #1;
        check("t3_enable", 64'(bus.pht_enable), 1);
        repeat (8) step();
        check("t3_occ_drained", 64'(bus.occupancy), 0);
        check("t3_ovf_sticky", 64'(bus.ovf_err), 1);

        // Drain with hold toggling
        bus.hold = 1'b1;
        enq(2'b11, 64'h400, 1'b1, 64'h404, 1'b1);
        enq(2'b01, 64'h408, 1'b0, 64'h0, 1'b0);
        check("t4_occ3", 64'(bus.occupancy), 3);
        base = deq_seen;
        bus.drain_req = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.hold = (c % 2 == 0);
            step();
            check("t4_ready_drain", 64'(bus.rt_ready), 0);
            if (bus.drained) done = 1'b1;
        end
        check("t4_drained", 64'(done), 1);
        check("t4_occ0", 64'(bus.occupancy), 0);
        check("t4_deq3", 64'(deq_seen - base), 3);
        bus.drain_req = 1'b0;
        bus.hold = 1'b0;
        step();
        check("t4_drained_off", 64'(bus.drained), 0);
        check("t4_ready_back", 64'(bus.rt_ready), 1);

        // Pointer wrap with continuous dequeue
        for (int i = 0; i < 20; i++) begin
            enq(2'b01, 64'h5000 + 64'(4*i), i[1], 64'h0, 1'b0);
            check("t5_occ_le2", 64'(bus.occupancy <= 2), 1);
        end
        repeat (2) step();
        check("t5_occ_end", 64'(bus.occupancy), 0);

        // Reset with entries queued
        bus.hold = 1'b1;
        enq(2'b11, 64'h600, 1'b1, 64'h604, 1'b0);
        enq(2'b11, 64'h608, 1'b1, 64'h60c, 1'b0);
        enq(2'b01, 64'h610, 1'b1, 64'h0, 1'b0);
        check("t6_occ5", 64'(bus.occupancy), 5);
        reset = 1'b1;
        bus.hold = 1'b0;
        exp_q.delete();
        #1;
        check("t6_branch_in_rst", 64'(bus.pht_rt_branch), 0);
        step();
        reset = 1'b0;
        #1;
        check("t6_occ0", 64'(bus.occupancy), 0);
        check("t6_branch", 64'(bus.pht_rt_branch), 0);
        check("t6_ovf", 64'(bus.ovf_err), 0);
        check("t6_ready", 64'(bus.rt_ready), 1);
        check("t6_drained", 64'(bus.drained), 0);

        repeat (3) step();
        check("sb_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
